// File: rtl/spi_slave_20_if.sv
// Bundles the SPI pins and the CPU register port of spi_slave_20.
// The slave modport is the design's view; the master modport drives it.
interface spi_slave_20_if;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [31:0] data_from_cpu;
  logic [31:0] data_to_cpu;
  logic        irq;
  logic        dataavailable;
  logic        readyfordata;

  modport slave (
    input  SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );

  modport master (
    output SCLK, SS_n, MOSI, spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata
  );
endinterface

// File: rtl/spi_slave_20.sv
// Mode-0 SPI slave with 20-bit words, oversampled on clk, and a CPU register
// port (rxdata, txdata, status, control) matching the 20-bit SPI master.
module spi_slave_20 #(
  parameter int DATABITS    = 20,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           reset,
  spi_slave_20_if.slave bus
);
  localparam int CW = $clog2(DATABITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATABITS - 1);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_ss_prev;
  logic [DATABITS-1:0]    r_rx_shift, r_tx_shift, r_tx_holding, r_rx_holding;
  logic [CW-1:0]          r_bitcnt;
  logic                   r_reload, r_tx_primed;
  logic                   r_rrdy, r_roe, r_toe, r_tur, r_fe;
  logic [7:0]             r_ctrl;
  logic [31:0]            r_data_to_cpu;
  logic                   r_irq, r_rd_d, r_wr_d;

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic w_load, w_tx_free, w_rd_lvl, w_wr_lvl, w_rd_strobe, w_wr_strobe;
  logic [DATABITS-1:0] w_rx_next;
  logic [7:0]          w_status;
  logic [31:0]         w_rd_mux;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_ss_fall   = ~w_ss_s & r_ss_prev;
  assign w_ss_rise   = w_ss_s & ~r_ss_prev;
  assign w_rx_next   = {r_rx_shift[DATABITS-2:0], w_mosi_s};

  // A new word is loaded at frame start and on the fall after each completed word.
  assign w_load    = w_ss_fall | (w_sclk_fall & r_reload & ~w_ss_s);
  // The holding register is free if empty or being drained by a load this cycle.
  assign w_tx_free = ~r_tx_primed | w_load;

  assign w_rd_lvl    = bus.spi_select & ~bus.read_n;
  assign w_wr_lvl    = bus.spi_select & ~bus.write_n;
  assign w_rd_strobe = w_rd_lvl & ~r_rd_d;
  assign w_wr_strobe = w_wr_lvl & ~r_wr_d;

  assign w_status = {r_rrdy, ~r_tx_primed, w_ss_s, r_toe, r_roe, r_tur, r_fe,
                     r_toe | r_roe | r_tur | r_fe};

  always_comb begin
    w_rd_mux = '0;
    case (bus.mem_addr)
      3'd0:    w_rd_mux = {{(32-DATABITS){1'b0}}, r_rx_holding};
      3'd2:    w_rd_mux = {24'b0, w_status};
      3'd3:    w_rd_mux = {24'b0, r_ctrl};
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
      r_sclk_prev <= w_sclk_s;
      r_ss_prev   <= w_ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_tx_holding  <= '0;
      r_rx_holding  <= '0;
      r_bitcnt      <= '0;
      r_reload      <= 1'b0;
      r_tx_primed   <= 1'b0;
      r_rrdy        <= 1'b0;
      r_roe         <= 1'b0;
      r_toe         <= 1'b0;
      r_tur         <= 1'b0;
      r_fe          <= 1'b0;
      r_ctrl        <= '0;
      r_data_to_cpu <= '0;
      r_irq         <= 1'b0;
      r_rd_d        <= 1'b0;
      r_wr_d        <= 1'b0;
    end else begin
      r_rd_d <= w_rd_lvl;
      r_wr_d <= w_wr_lvl;

      // Clears come first so that a flag set in the same cycle wins.
      if (w_rd_strobe && bus.mem_addr == 3'd0) r_rrdy <= 1'b0;
      if (w_wr_strobe && bus.mem_addr == 3'd2) begin
        r_rrdy <= 1'b0;
        r_roe  <= 1'b0;
        r_toe  <= 1'b0;
        r_tur  <= 1'b0;
        r_fe   <= 1'b0;
      end
      if (w_wr_strobe && bus.mem_addr == 3'd3) r_ctrl <= bus.data_from_cpu[7:0];

      if (w_load) begin
        if (r_tx_primed) begin
          r_tx_shift  <= r_tx_holding;
          r_tx_primed <= 1'b0;
        end else begin
          r_tx_shift <= '0;
          r_tur      <= 1'b1;
        end
        r_bitcnt <= '0;
        r_reload <= 1'b0;
      end else if (w_sclk_fall && !w_ss_s && r_bitcnt != '0) begin
        r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};
      end

      if (w_sclk_rise && !w_ss_s) begin
        r_rx_shift <= w_rx_next;
        if (r_bitcnt == LAST_BIT) begin
          r_rx_holding <= w_rx_next;
          r_rrdy       <= 1'b1;
          if (r_rrdy) r_roe <= 1'b1;
          r_bitcnt     <= '0;
          r_reload     <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end

      if (w_ss_rise) begin
        if (r_bitcnt != '0) r_fe <= 1'b1;
        r_bitcnt <= '0;
        r_reload <= 1'b0;
      end

      // Placed after the load so a same-cycle write re-primes the holding register.
      if (w_wr_strobe && bus.mem_addr == 3'd1) begin
        if (w_tx_free) begin
          r_tx_holding <= bus.data_from_cpu[DATABITS-1:0];
          r_tx_primed  <= 1'b1;
        end else begin
          r_toe <= 1'b1;
        end
      end

      r_data_to_cpu <= w_rd_mux;
      r_irq         <= |(w_status & r_ctrl);
    end
  end

  assign bus.MISO          = r_tx_shift[DATABITS-1];
  assign bus.MISO_oe       = ~w_ss_s;
  assign bus.data_to_cpu   = r_data_to_cpu;
  assign bus.irq           = r_irq;
  assign bus.dataavailable = r_rrdy;
  assign bus.readyfordata  = ~r_tx_primed;
endmodule
